// File: rtl/instr_encoder_loader_pkg.sv
// Shared MIPS definitions: opcode constants, loader record kinds and FSM state codes.
// The main decoder uses the same opcode constants.
package instr_encoder_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        KindRtype = 3'd0,
        KindLw    = 3'd1,
        KindSw    = 3'd2,
        KindBeq   = 3'd3,
        KindAddi  = 3'd4,
        KindJ     = 3'd5
    } kind_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StLoad = 1'b1
    } state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational encoder: record kind plus fields -> legal flag and 32-bit MIPS word.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        legal,
    output logic [31:0] word
);

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (kind)
            KindRtype: word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
            KindLw:    word = {OP_LW, rs, rt, imm};
            KindSw:    word = {OP_SW, rs, rt, imm};
            KindBeq:   word = {OP_BEQ, rs, rt, imm};
            KindAddi:  word = {OP_ADDI, rs, rt, imm};
            KindJ:     word = {OP_J, target};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded MIPS words into instruction memory from field records while holding the CPU.
// One registered write per accepted legal record; session ends on the last record or overflow.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                legal;
    logic [31:0]         word;

    instr_field_packer u_packer (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .legal  (legal),
        .word   (word)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word;
                        ptr_d   = ptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                        // Writing the top word with more to come: stop instead of wrapping.
                        if (!in_last && ptr_q == LAST_PTR) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == StLoad);
    assign cpu_hold   = (state_q == StLoad);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed load scenarios plus randomized sessions against a session model.
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int BASE  = 0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, in_valid, in_last, in_ready;
    logic [2:0]    in_kind;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          imem_we, cpu_hold, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    // Session model state
    bit          m_open;
    int          m_ptr, m_count;
    bit          m_err, exp_we, exp_done;
    int          exp_addr;
    logic [31:0] exp_data;
    logic [31:0] wr_data[$];
    int          wr_addr[$];

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int k);
        logic [31:0] op, rs, rt, rd, fn, im, tg;
        rs = 32'(in_rs); rt = 32'(in_rt); rd = 32'(in_rd);
        fn = 32'(in_funct); im = 32'(in_imm); tg = 32'(in_target);
        case (k)
            0: op = 0;
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 8;
            default: op = 2;
        endcase
        if (k == 0) return (rs << 21) + (rt << 16) + (rd << 11) + fn;
        if (k == 5) return (op << 26) + tg;
        return (op << 26) + (rs << 21) + (rt << 16) + im;
    endfunction

    task automatic model_reset();
        m_open = 0; m_ptr = BASE; m_count = 0; m_err = 0;
    endtask

    task automatic step();
        bit ends;
        @(posedge clk);
        exp_we = 0; exp_done = 0; ends = 0;
        if (!m_open) begin
            if (start) begin
                m_open = 1; m_ptr = BASE; m_count = 0; m_err = 0;
            end
        end else if (in_valid) begin
            if (in_kind <= 5) begin
                exp_we = 1; exp_addr = m_ptr; exp_data = ref_word(int'(in_kind));
                m_count++;
                if (!in_last && m_ptr == DEPTH - 1) begin
                    m_err = 1; ends = 1;
                end
                m_ptr++;
            end else begin
                m_err = 1;
            end
            if (in_last) ends = 1;
            if (ends) begin
                m_open = 0; exp_done = 1;
            end
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(m_open));
        check("cpu_hold", 32'(cpu_hold), 32'(m_open));
        check("imem_we", 32'(imem_we), 32'(exp_we));
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(m_err));
        check("count", 32'(count), 32'(m_count));
        if (exp_we) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_addr));
            check("imem_wdata", imem_wdata, exp_data);
        end
        if (imem_we) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    endtask

    task automatic set_rec(input bit v, input int k, input int rs, input int rt, input int rd,
                           input int fn, input int im, input int tg, input bit last);
        in_valid = v; in_kind = 3'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_funct = 6'(fn); in_imm = 16'(im); in_target = 26'(tg); in_last = last;
    endtask

    task automatic rand_fields();
        in_kind = 3'($urandom_range(0, 7)); in_rs = 5'($urandom); in_rt = 5'($urandom);
        in_rd = 5'($urandom); in_funct = 6'($urandom); in_imm = 16'($urandom);
        in_target = 26'($urandom); in_last = ($urandom_range(0, 4) == 0);
    endtask

    task automatic do_start();
        start = 1; step(); start = 0;
    endtask

    task automatic do_reset();
        #2 reset_n = 0;
        #1;
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(in_ready), 0);
        model_reset();
        #2 reset_n = 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0; start = 0;
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12 reset_n = 1;
        step();

        // 1: reset mid-stream after three writes, then restart at base
        do_start();
        for (int i = 0; i < 3; i++) begin
            set_rec(1, 4, i, i + 1, 0, 0, i, 0, 0);
            step();
        end
        do_reset();
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_start();
        set_rec(1, 5, 0, 0, 0, 0, 0, 'h77, 1);
        step();
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // 2: three-instruction program
        wr_addr.delete(); wr_data.delete();
        do_start();
        set_rec(1, 0, 1, 2, 3, 'h20, 0, 0, 0); step();
        set_rec(1, 1, 0, 4, 0, 0, 8, 0, 0);    step();
        set_rec(1, 5, 0, 0, 0, 0, 0, 'h10, 1); step();
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0);    step();
        check("t2_nwr", 32'(wr_data.size()), 3);
        if (wr_data.size() == 3) begin
            check("t2_w0", wr_data[0], 32'h00221820);
            check("t2_w1", wr_data[1], 32'h8C040008);
            check("t2_w2", wr_data[2], 32'h08000010);
            check("t2_a2", 32'(wr_addr[2]), 2);
        end
        check("t2_count", 32'(count), 3);

        // 3: gaps in in_valid, and valid held while idle
        wr_addr.delete(); wr_data.delete();
        set_rec(1, 4, 1, 1, 0, 0, 5, 0, 0); step();
        do_start();
        set_rec(1, 4, 1, 1, 0, 0, 5, 0, 0); step();
        set_rec(0, 4, 1, 1, 0, 0, 6, 0, 0); step();
        set_rec(1, 4, 1, 1, 0, 0, 7, 0, 1); step();
        set_rec(1, 4, 1, 1, 0, 0, 8, 0, 0); step(); step();
        check("t3_nwr", 32'(wr_data.size()), 2);

        // 4: illegal kind between two legal records
        wr_addr.delete(); wr_data.delete();
        do_start();
        set_rec(1, 2, 1, 2, 0, 0, 'hFFFC, 0, 0); step();
        set_rec(1, 7, 3, 3, 3, 0, 0, 0, 0);      step();
        set_rec(1, 3, 1, 2, 0, 0, 'hFFFF, 0, 1); step();
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0);      step();
        check("t4_err", 32'(err), 1);
        check("t4_count", 32'(count), 2);
        if (wr_data.size() == 2) begin
            check("t4_w0", wr_data[0], 32'hAC22FFFC);
            check("t4_w1", wr_data[1], 32'h1022FFFF);
            check("t4_a1", 32'(wr_addr[1]), 1);
        end else check("t4_nwr", 32'(wr_data.size()), 2);

        // 5: overflow with five non-last legal records
        wr_addr.delete(); wr_data.delete();
        do_start();
        for (int i = 0; i < 5; i++) begin
            set_rec(1, 4, 2, 3, 0, 0, i, 0, 0); step();
        end
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("t5_nwr", 32'(wr_data.size()), 4);
        check("t5_err", 32'(err), 1);

        // 6: start during load ignored; start clears stale err
        wr_addr.delete(); wr_data.delete();
        do_start();
        check("t6_errclr", 32'(err), 0);
        start = 1;
        set_rec(1, 1, 5, 6, 0, 0, 4, 0, 0); step();
        set_rec(1, 1, 5, 6, 0, 0, 8, 0, 1); step();
        start = 0;
        set_rec(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        if (wr_addr.size() == 2) check("t6_a1", 32'(wr_addr[1]), 1);
        else check("t6_nwr", 32'(wr_addr.size()), 2);

        // randomized sessions
        for (int s = 0; s < 150; s++) begin
            start = 1; in_valid = 1'($urandom); rand_fields();
            step();
            start = 0;
            for (int c = 0; c < 30 && m_open; c++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 7) == 0);
                rand_fields();
                step();
                if (m_open && $urandom_range(0, 60) == 0) do_reset();
            end
            start = 0;
            in_valid = 1'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
